mips_alu: RTL and testbench

- 32-bit MIPS integer ALU instantiated inside the EXE stage.
- Computes the combinational result for arithmetic, logic, shift, compare, LUI and HI/LO move operations.
- Computes next HI/LO values for multiply/divide and MTHI/MTLO, and registers them.
- EXE feeds it an inverted system clock, so HI_OUT/LO_OUT settle mid-cycle and EXE latches them into its HI/LO registers on the next system posedge.

---
 rtl/mips_alu_pkg.sv | 47 ++++
 rtl/mips_muldiv.sv | 80 ++++++++
 rtl/mips_alu.sv | 76 +++++++
 tb/tb_mips_alu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS integer ALU: data width and the 6-bit
// operation codes driven by the EXE-stage decoder.
package mips_alu_pkg;

  localparam int XLEN = 32;

  // Arithmetic / logic
  localparam logic [5:0] OP_AND   = 6'h00;
  localparam logic [5:0] OP_OR    = 6'h01;
  localparam logic [5:0] OP_ADD   = 6'h02;
  localparam logic [5:0] OP_ADDU  = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_NOR   = 6'h05;
  localparam logic [5:0] OP_SUB   = 6'h06;
  localparam logic [5:0] OP_SUBU  = 6'h07;

  // Compare and shift
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_SLL   = 6'h0A;
  localparam logic [5:0] OP_SRL   = 6'h0B;
  localparam logic [5:0] OP_SRA   = 6'h0C;
  localparam logic [5:0] OP_SLLV  = 6'h0D;
  localparam logic [5:0] OP_SRLV  = 6'h0E;
  localparam logic [5:0] OP_SRAV  = 6'h0F;

  // Upper immediate, multiply/divide and HI/LO moves
  localparam logic [5:0] OP_LUI   = 6'h10;
  localparam logic [5:0] OP_MULT  = 6'h11;
  localparam logic [5:0] OP_MULTU = 6'h12;
  localparam logic [5:0] OP_DIV   = 6'h13;
  localparam logic [5:0] OP_DIVU  = 6'h14;
  localparam logic [5:0] OP_MFHI  = 6'h15;
  localparam logic [5:0] OP_MFLO  = 6'h16;
  localparam logic [5:0] OP_MTHI  = 6'h17;
  localparam logic [5:0] OP_MTLO  = 6'h18;

  // Arithmetic right shift written out explicitly so the sign fill does not
  // depend on signedness propagation through surrounding expressions.
  function automatic logic [XLEN-1:0] sra32(input logic [XLEN-1:0] val,
                                            input logic [4:0]      amt);
    logic [XLEN-1:0] fill;
    fill  = val[XLEN-1] ? ~({XLEN{1'b1}} >> amt) : '0;
    sra32 = (val >> amt) | fill;
  endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Combinational next-value logic for the HI/LO pair: signed/unsigned
// multiply, signed/unsigned divide (with divide-by-zero and INT_MIN/-1
// handling) and the MTHI/MTLO moves. Anything else holds HI_IN/LO_IN.
module mips_muldiv
  import mips_alu_pkg::*;
(
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic             div_zero;
  logic             div_ovf;
  logic [XLEN-1:0]  div_b;
  logic [XLEN-1:0]  quot_s;
  logic [XLEN-1:0]  rem_s;
  logic [XLEN-1:0]  quot_u;
  logic [XLEN-1:0]  rem_u;

  // Products: operands widened to 64 bits so the low 64 bits of the product
  // are exact for both signed and unsigned interpretations.
  always_comb begin
    prod_s = {{32{a[XLEN-1]}}, a} * {{32{b[XLEN-1]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
  end

  // Divider: the divisor is forced to 1 for the zero and overflow cases so
  // the array never sees an undefined operation; those cases are overridden
  // when HI/LO are selected below.
  always_comb begin
    div_zero = (b == '0);
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    div_b    = (div_zero || div_ovf) ? 32'd1 : b;
    quot_s   = $signed(a) / $signed(div_b);
    rem_s    = $signed(a) % $signed(div_b);
    quot_u   = a / div_b;
    rem_u    = a % div_b;
  end

  // HI/LO selection; default is to hold the architectural values.
  always_comb begin
    hi_next = hi_in;
    lo_next = lo_in;
    case (op)
      OP_MULT: begin
        hi_next = prod_s[63:32];
        lo_next = prod_s[31:0];
      end
      OP_MULTU: begin
        hi_next = prod_u[63:32];
        lo_next = prod_u[31:0];
      end
      OP_DIV: begin
        if (div_ovf) begin
          hi_next = '0;
          lo_next = 32'h8000_0000;
        end else if (!div_zero) begin
          hi_next = rem_s;
          lo_next = quot_s;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          hi_next = rem_u;
          lo_next = quot_u;
        end
      end
      OP_MTHI: hi_next = a;
      OP_MTLO: lo_next = a;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// 32-bit MIPS integer ALU for the EXE stage. aluResult is a zero-latency
// combinational mux; the next HI/LO pair from mips_muldiv is registered on
// CLK (the inverted system clock), so HI_OUT/LO_OUT are stable by the next
// system posedge. There is no valid/ready handshake: every operation,
// including multiply and divide, completes and is captured in one cycle.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALU_control,
  input  logic [4:0]  shiftAmount,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  output logic [31:0] aluResult,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT
);

  logic [XLEN-1:0] hi_next;
  logic [XLEN-1:0] lo_next;
  logic [4:0]      var_amt;

  assign var_amt = A[4:0];

  mips_muldiv u_muldiv (
    .op      (ALU_control),
    .a       (A),
    .b       (B),
    .hi_in   (HI_IN),
    .lo_in   (LO_IN),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Result mux; ops that only affect HI/LO (and unknown codes) return zero.
  always_comb begin
    aluResult = '0;
    case (ALU_control)
      OP_AND:  aluResult = A & B;
      OP_OR:   aluResult = A | B;
      OP_ADD,
      OP_ADDU: aluResult = A + B;
      OP_XOR:  aluResult = A ^ B;
      OP_NOR:  aluResult = ~(A | B);
      OP_SUB,
      OP_SUBU: aluResult = A - B;
      OP_SLT:  aluResult = {31'b0, ($signed(A) < $signed(B))};
      OP_SLTU: aluResult = {31'b0, (A < B)};
      OP_SLL:  aluResult = B << shiftAmount;
      OP_SRL:  aluResult = B >> shiftAmount;
      OP_SRA:  aluResult = sra32(B, shiftAmount);
      OP_SLLV: aluResult = B << var_amt;
      OP_SRLV: aluResult = B >> var_amt;
      OP_SRAV: aluResult = sra32(B, var_amt);
      OP_LUI:  aluResult = {B[15:0], 16'h0000};
      OP_MFHI: aluResult = HI_IN;
      OP_MFLO: aluResult = LO_IN;
      default: aluResult = '0;
    endcase
  end

  // HI/LO registers: cleared asynchronously, loaded every edge otherwise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HI_OUT <= '0;
      LO_OUT <= '0;
    end else begin
      HI_OUT <= hi_next;
      LO_OUT <= lo_next;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases for each operation class
// and its corner cases, asynchronous reset behaviour, then randomized ops
// checked against a reference model through an expected-value queue.
module tb_mips_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  ctl;
  logic [4:0]  sh;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic [31:0] alu_result;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks;
  int n_errors;

  // {result, hi, lo}
  logic [95:0] exp_q[$];

  mips_alu dut (
    .CLK         (clk),
    .RESET       (rst),
    .A           (a),
    .B           (b),
    .ALU_control (ctl),
    .shiftAmount (sh),
    .HI_IN       (hi_in),
    .LO_IN       (lo_in),
    .aluResult   (alu_result),
    .HI_OUT      (hi_out),
    .LO_OUT      (lo_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [95:0] model(input logic [5:0] op, input logic [31:0] ma,
                                        input logic [31:0] mb, input logic [4:0] msh,
                                        input logic [31:0] mhi, input logic [31:0] mlo);
    logic [31:0] r, nh, nl, ua, ub, q, m, fill;
    logic [63:0] p;
    logic [4:0]  amt;
    r = '0; nh = mhi; nl = mlo;
    ua = ma[31] ? (~ma + 32'd1) : ma;
    ub = mb[31] ? (~mb + 32'd1) : mb;
    amt = (op == 6'h0C) ? msh : ma[4:0];
    fill = mb[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0;
    case (op)
      6'h00: r = ma & mb;
      6'h01: r = ma | mb;
      6'h02, 6'h03: r = ma + mb;
      6'h04: r = ma ^ mb;
      6'h05: r = ~(ma | mb);
      6'h06, 6'h07: r = ma - mb;
      6'h08: r = (ma[31] != mb[31]) ? {31'b0, ma[31]} : {31'b0, (ma < mb)};
      6'h09: r = {31'b0, (ma < mb)};
      6'h0A: r = mb << msh;
      6'h0B: r = mb >> msh;
      6'h0C, 6'h0F: r = (mb >> amt) | fill;
      6'h0D: r = mb << ma[4:0];
      6'h0E: r = mb >> ma[4:0];
      6'h10: r = {mb[15:0], 16'h0};
      6'h11: begin
        p = {32'b0, ua} * {32'b0, ub};
        if (ma[31] ^ mb[31]) p = ~p + 64'd1;
        nh = p[63:32]; nl = p[31:0];
      end
      6'h12: begin
        p = {32'b0, ma} * {32'b0, mb};
        nh = p[63:32]; nl = p[31:0];
      end
      6'h13: if (mb != 0) begin
        q = ua / ub; m = ua % ub;
        nl = (ma[31] ^ mb[31]) ? (~q + 32'd1) : q;
        nh = ma[31] ? (~m + 32'd1) : m;
      end
      6'h14: if (mb != 0) begin
        nl = ma / mb; nh = ma % mb;
      end
      6'h15: r = mhi;
      6'h16: r = mlo;
      6'h17: nh = ma;
      6'h18: nl = ma;
      default: ;
    endcase
    return {r, nh, nl};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one op mid-cycle, queue its expectation, check aluResult before the
  // capturing edge and HI/LO just after it.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] ta,
                        input logic [31:0] tb, input logic [4:0] tsh,
                        input logic [31:0] thi, input logic [31:0] tlo,
                        input logic [31:0] er, input logic [31:0] eh, input logic [31:0] el);
    logic [95:0] item;
    @(negedge clk);
    ctl = op; a = ta; b = tb; sh = tsh; hi_in = thi; lo_in = tlo;
    exp_q.push_back({er, eh, el});
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      item = exp_q.pop_front();
      check({tag, ".res"}, alu_result, item[95:64]);
      @(posedge clk);
      #1;
      check({tag, ".hi"}, hi_out, item[63:32]);
      check({tag, ".lo"}, lo_out, item[31:0]);
    end
  endtask

  task automatic run_model(input string tag, input logic [5:0] op, input logic [31:0] ta,
                           input logic [31:0] tb, input logic [4:0] tsh,
                           input logic [31:0] thi, input logic [31:0] tlo);
    logic [95:0] e;
    e = model(op, ta, tb, tsh, thi, tlo);
    run_op(tag, op, ta, tb, tsh, thi, tlo, e[95:64], e[63:32], e[31:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; a = '0; b = '0; ctl = 6'h11; sh = '0; hi_in = 32'h1111; lo_in = 32'h2222;
    repeat (2) @(posedge clk);
    #1;
    check("reset.hi", hi_out, 32'h0);
    check("reset.lo", lo_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases (HI_IN/LO_IN chosen so holds are visible)
    run_op("add",   6'h02, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'hA1, 32'hB1, 32'h8000_0000, 32'hA1, 32'hB1);
    run_op("sub",   6'h06, 32'd3, 32'd5, 5'd0, 32'hA2, 32'hB2, 32'hFFFF_FFFE, 32'hA2, 32'hB2);
    run_op("slt",   6'h08, 32'd3, 32'd5, 5'd0, 32'h0, 32'h0, 32'd1, 32'h0, 32'h0);
    run_op("sltneg",6'h08, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0, 32'd1, 32'h0, 32'h0);
    run_op("sltu",  6'h09, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0, 32'd0, 32'h0, 32'h0);
    run_op("sra",   6'h0C, 32'h0, 32'h8000_0010, 5'd4, 32'h0, 32'h0, 32'hF800_0001, 32'h0, 32'h0);
    run_op("srlv",  6'h0E, 32'h24, 32'h8000_0000, 5'd0, 32'h0, 32'h0, 32'h0800_0000, 32'h0, 32'h0);
    run_op("lui",   6'h10, 32'h0, 32'h1234, 5'd0, 32'h0, 32'h0, 32'h1234_0000, 32'h0, 32'h0);
    run_op("multu", 6'h12, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFE);
    run_op("div",   6'h13, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  6'h14, 32'd7, 32'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'd1, 32'd3);
    run_op("div0",  6'h13, 32'd7, 32'd0, 5'd0, 32'hAA, 32'hBB, 32'h0, 32'hAA, 32'hBB);
    run_op("divu0", 6'h14, 32'd7, 32'd0, 5'd0, 32'hAA, 32'hBB, 32'h0, 32'hAA, 32'hBB);
    run_op("divovf",6'h13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h5, 32'h6, 32'h0, 32'h0, 32'h8000_0000);
    run_op("mthi",  6'h17, 32'h55, 32'h0, 5'd0, 32'h0, 32'd9, 32'h0, 32'h55, 32'd9);
    run_op("mtlo",  6'h18, 32'h66, 32'h0, 5'd0, 32'h77, 32'd9, 32'h0, 32'h77, 32'h66);
    run_op("mfhi",  6'h15, 32'h0, 32'h0, 5'd0, 32'h55, 32'h44, 32'h55, 32'h55, 32'h44);
    run_op("mflo",  6'h16, 32'h0, 32'h0, 5'd0, 32'h55, 32'h44, 32'h44, 32'h55, 32'h44);
    run_op("nop",   6'h3F, 32'h12, 32'h34, 5'd3, 32'h9, 32'h8, 32'h0, 32'h9, 32'h8);
    run_op("mult",  6'h11, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Asynchronous reset mid-cycle with MULT still on the inputs
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst.hi", hi_out, 32'h0);
    check("arst.lo", lo_out, 32'h0);
    @(posedge clk);
    #1;
    check("arst_edge.hi", hi_out, 32'h0);
    check("arst_edge.lo", lo_out, 32'h0);
    check("arst.res", alu_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 6'h11, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb;
      logic [5:0]  rop;
      rop = 6'($urandom_range(0, 31));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_model("rand", rop, ra, rb, 5'($urandom_range(0, 31)), $urandom, $urandom);
    end

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
